wave_capture: RTL and testbench
===============================

WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter DEPTH_LOG2, default 9, meaning capture buffer holds 2**DEPTH_LOG2 samples (default 512).
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  block enable; low forces IDLE.
REQ-005 arm  input  1  single-cycle pulse starting a new capture.
REQ-006 trig_force  input  1  forces trigger on next decimated sample while ARMED.
REQ-007 ADC_out  input  14  ADC sample, offset binary, midscale 14'd8192.
REQ-008 state_div  input  8  decimation: one sample kept every state_div+1 clocks.
REQ-009 state_trig_level  input  14  rising-edge trigger threshold, offset binary.
REQ-010 rd_addr  input  DEPTH_LOG2  buffer read address.
REQ-011 rd_data  output  14  buffer read data.
REQ-012 busy  output  1  high in ARMED or CAPTURE.
REQ-013 done  output  1  high in DONE.
REQ-014 pk_max  output  14  largest sample written in current/last capture.
REQ-015 pk_min  output  14  smallest sample written in current/last capture.
REQ-016 amp_pp  output  14  pk_max minus pk_min of last completed capture.

Function
REQ-017 ADC_out SHALL be registered once before any use; all comparisons and writes use the registered sample.
REQ-018 state_div SHALL be latched on accepted arm; decimation counter SHALL reset to 0 on arm and assert strobe when it equals the latched value, then wrap to 0.
REQ-019 States SHALL be IDLE, ARMED, CAPTURE, DONE.
REQ-020 IDLE or DONE + arm (en high): SHALL go ARMED, clear done, reset pk_max to 0, pk_min to 16383, write pointer to 0.
REQ-021 arm in ARMED or CAPTURE SHALL be ignored.
REQ-022 ARMED: trigger SHALL occur on a strobe where previous strobed sample < state_trig_level and current strobed sample >= state_trig_level; first strobe after arm only records previous sample and cannot trigger by crossing.
REQ-023 trig_force high in ARMED SHALL trigger on the next strobe, including the first; trig_force outside ARMED ignored.
REQ-024 Triggering sample SHALL be written to address 0 and state SHALL go CAPTURE; each later strobe writes the next address.
REQ-025 After writing address 2**DEPTH_LOG2-1, state SHALL go DONE on the following clock; no wrap-around, no further writes.
REQ-026 Each written sample SHALL update pk_max/pk_min in the same clock as the write (unsigned compare).
REQ-027 amp_pp SHALL update once, registered on the clock entering DONE, including the last sample; holds until the next DONE.
REQ-028 Read: rd_data SHALL be registered, latency 1 clock from rd_addr, available in every state; simultaneous read/write to the same address returns the old contents.
REQ-029 en low SHALL force IDLE on the next clock from any state, clearing done and busy; buffer, pk_*, amp_pp retained.

Reset
REQ-030 rst SHALL force IDLE, busy=0, done=0, pk_max=0, pk_min=16383, amp_pp=0, rd_data=0, write pointer and decimation counter 0.
REQ-031 rst mid-capture SHALL abort; buffer contents not cleared and unspecified.
REQ-032 rst SHALL take priority over arm, en and trig_force in the same clock.

Configuration
REQ-033 Macro WAVE_CAPTURE_PEAK_EN: defined -> pk_max, pk_min, amp_pp per REQ-026/027; undefined -> peak logic omitted, pk_max, pk_min, amp_pp tied to 0.

Verification
REQ-034 state_div=0, level=8192, arm, ramp 8000..8703 step 1 -> trigger at sample 8192, buffer[0]=8192, buffer[511]=8703, done after 512 writes.
REQ-035 state_div=3, trig_force, constant 5000 -> strobes every 4 clocks, busy for 2048+ clocks, all 512 entries 5000, amp_pp=0 (PEAK_EN).
REQ-036 Full-scale sine from sin-table DAC path looped back, level=8192 -> buffer[0] >= 8192 with previous < 8192; amp_pp within 2 LSB of 16383-0 swing expected.
REQ-037 Capture running, rst at write 100 -> next clock busy=0, done=0, pk_min=16383; new arm captures normally.
REQ-038 Signal stuck at 9000, level=8192, no force -> stays ARMED indefinitely; en low -> IDLE next clock.
REQ-039 After done, rd_addr 0..511 swept -> rd_data equals written samples with 1-clock latency; arm while ARMED ignored.

Source files
------------

// File: rtl/wave_capture.sv
// wave_capture: triggered, decimated ADC waveform capture into an on-chip
// buffer with optional peak/peak-to-peak measurement.
//
// Optional feature macro: WAVE_CAPTURE_PEAK_EN
//   defined   -> pk_max / pk_min track the samples of the current capture and
//                amp_pp is latched on the clock entering DONE
//   undefined -> peak logic omitted, pk_max / pk_min / amp_pp tied to 0
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                block enable, low returns to IDLE
//   arm               pulse starting a new capture (from IDLE or DONE)
//   trig_force        force a trigger on the next decimated sample while armed
//   ADC_out           14-bit offset-binary ADC sample
//   state_div         decimation, keep one sample every state_div+1 clocks
//   state_trig_level  rising-edge trigger threshold
//   rd_addr / rd_data buffer read port, 1-clock latency
//   busy, done        ARMED|CAPTURE, DONE status
//   pk_max, pk_min    extremes of samples written in the current/last capture
//   amp_pp            pk_max - pk_min of the last completed capture
module wave_capture #(
  parameter int unsigned DEPTH_LOG2 = 9,
  localparam int unsigned DW = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  arm,
  input  logic                  trig_force,
  input  logic [DW-1:0]         ADC_out,
  input  logic [7:0]            state_div,
  input  logic [DW-1:0]         state_trig_level,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DW-1:0]         rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [DW-1:0]         pk_max,
  output logic [DW-1:0]         pk_min,
  output logic [DW-1:0]         amp_pp
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = DEPTH_LOG2'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           adc_q;
  logic [DW-1:0]           prev_q;
  logic                    have_prev_q;
  logic                    force_pend_q;
  logic [7:0]              div_lat_q;
  logic [7:0]              div_cnt_q;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [DW-1:0]           mem [DEPTH];

  logic active_c, strobe_c, arm_c, cross_c, wr_c;

  // Input sample register; every comparison and write uses adc_q.
  always_ff @(posedge clk) begin
    if (rst) adc_q <= '0;
    else     adc_q <= ADC_out;
  end

  assign active_c = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign strobe_c = active_c && (div_cnt_q == div_lat_q);
  assign arm_c    = en && arm && ((state_q == S_IDLE) || (state_q == S_DONE));
  // The first strobe after arm has no valid previous sample, so it cannot cross.
  assign cross_c  = have_prev_q && (prev_q < state_trig_level) &&
                    (adc_q >= state_trig_level);

  // Next-state and write-enable logic.
  always_comb begin
    state_d = state_q;
    wr_c    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: if (arm) state_d = S_ARMED;
      S_ARMED: begin
        if (strobe_c && (trig_force || force_pend_q || cross_c)) begin
          state_d = S_CAPTURE;
          wr_c    = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (strobe_c) begin
          wr_c = 1'b1;
          if (wr_ptr_q == LAST_ADDR) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!en) begin
      state_d = S_IDLE;
      wr_c    = 1'b0;
    end
  end

  // State, status and capture bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      force_pend_q <= 1'b0;
      div_lat_q    <= '0;
      div_cnt_q    <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
      done    <= (state_d == S_DONE);
      if (arm_c) begin
        div_lat_q    <= state_div;
        div_cnt_q    <= '0;
        wr_ptr_q     <= '0;
        have_prev_q  <= 1'b0;
        force_pend_q <= 1'b0;
      end else begin
        if (active_c)
          div_cnt_q <= (div_cnt_q == div_lat_q) ? 8'd0 : div_cnt_q + 8'd1;
        if (wr_c)
          wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
        if ((state_q == S_ARMED) && strobe_c) begin
          prev_q      <= adc_q;
          have_prev_q <= 1'b1;
        end
        // Remember a force seen between strobes so it fires on the next one.
        if ((state_q == S_ARMED) && trig_force)
          force_pend_q <= 1'b1;
      end
    end
  end

  // Capture buffer: write port plus registered read (old data on collision).
  always_ff @(posedge clk) begin
    if (wr_c && !rst) mem[wr_ptr_q] <= adc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

`ifdef WAVE_CAPTURE_PEAK_EN
  logic [DW-1:0] pk_max_nx_c, pk_min_nx_c;

  assign pk_max_nx_c = (adc_q > pk_max) ? adc_q : pk_max;
  assign pk_min_nx_c = (adc_q < pk_min) ? adc_q : pk_min;

  // Peak tracking; amp_pp folds in the final sample on the DONE-entry clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      pk_max <= '0;
      pk_min <= {DW{1'b1}};
      amp_pp <= '0;
    end else if (arm_c) begin
      pk_max <= '0;
      pk_min <= {DW{1'b1}};
    end else if (wr_c) begin
      pk_max <= pk_max_nx_c;
      pk_min <= pk_min_nx_c;
      if (state_d == S_DONE) amp_pp <= pk_max_nx_c - pk_min_nx_c;
    end
  end
`else
  assign pk_max = '0;
  assign pk_min = '0;
  assign amp_pp = '0;
`endif

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: randomized captures compared with a
// sample-list reference model (decimate, find trigger, take 512 samples).
module tb_wave_capture;

  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 512;
`ifdef WAVE_CAPTURE_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, arm, trig_force;
  logic [13:0]   ADC_out;
  logic [7:0]    state_div;
  logic [13:0]   state_trig_level;
  logic [AW-1:0] rd_addr;
  logic [13:0]   rd_data;
  logic          busy, done;
  logic [13:0]   pk_max, pk_min, amp_pp;

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] hist [$];
  logic [13:0] exp_buf [DEPTH];

  always #5 clk = ~clk;

  wave_capture #(.DEPTH_LOG2(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .arm(arm), .trig_force(trig_force),
    .ADC_out(ADC_out), .state_div(state_div),
    .state_trig_level(state_trig_level), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done),
    .pk_max(pk_max), .pk_min(pk_min), .amp_pp(amp_pp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: value v is what the DUT samples at the coming rising edge.
  task automatic drive_cycle(input logic [13:0] v);
    ADC_out = v;
    hist.push_back(v);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] gen(input int mode, input int base, input int n);
    int v;
    case (mode)
      0:       v = (base + n > 16383) ? 16383 : base + n;
      1:       v = int'($urandom_range(16383, 0));
      default: v = base;
    endcase
    return 14'(v);
  endfunction

  // Arm, feed samples until done, then compare the buffer with the model.
  task automatic run_capture(input int d, input int lvl, input bit frc,
                             input int mode, input int base, output int busy_cycles);
    int jt, last_idx, mx, mn, sp, sc;
    hist.delete();
    state_div        = 8'(d);
    state_trig_level = 14'(lvl);
    trig_force       = frc;
    arm              = 1'b1;
    drive_cycle(gen(mode, base, 0));
    arm         = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int n = 1; n < 20000 && !done; n++) begin
      drive_cycle(gen(mode, base, n));
      if (busy) busy_cycles++;
    end
    trig_force = 1'b0;
    chk("capture_done", done, 1);
    chk("busy_after_done", busy, 0);

    // Strobed sample j is the value presented d + j*(d+1) clocks after arm.
    jt = -1;
    for (int j = 1; d + j * (d + 1) < hist.size(); j++) begin
      sp = int'(hist[d + (j - 1) * (d + 1)]);
      sc = int'(hist[d + j * (d + 1)]);
      if (frc || (sp < lvl && sc >= lvl)) begin
        jt = frc ? 0 : j;
        break;
      end
    end
    last_idx = d + (jt + DEPTH - 1) * (d + 1);
    chk("model_has_data", (jt >= 0) && (last_idx < hist.size()), 1);
    mx = 0;
    mn = 16383;
    for (int i = 0; i < DEPTH; i++) begin
      if (jt >= 0 && d + (jt + i) * (d + 1) < hist.size())
        exp_buf[i] = hist[d + (jt + i) * (d + 1)];
      else
        exp_buf[i] = '0;
      if (int'(exp_buf[i]) > mx) mx = int'(exp_buf[i]);
      if (int'(exp_buf[i]) < mn) mn = int'(exp_buf[i]);
    end
    chk("pk_max", pk_max, PEAK ? mx : 0);
    chk("pk_min", pk_min, PEAK ? mn : 0);
    chk("amp_pp", amp_pp, PEAK ? mx - mn : 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      @(posedge clk);
      #1;
      chk($sformatf("rd_data[%0d]", i), rd_data, exp_buf[i]);
    end
  endtask

  task automatic read_at(input int addr, output logic [13:0] v);
    rd_addr = AW'(addr);
    @(posedge clk);
    #1;
    v = rd_data;
  endtask

  initial begin
    int bc;
    logic [13:0] v;
    rst = 1'b1; en = 1'b1; arm = 1'b0; trig_force = 1'b0;
    ADC_out = '0; state_div = '0; state_trig_level = 14'd8192; rd_addr = '0;
    repeat (3) drive_cycle(14'd0);
    // Reset values, checked while reset is still asserted.
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pk_max", pk_max, 0);
    chk("rst_pk_min", pk_min, PEAK ? 16383 : 0);
    chk("rst_amp_pp", amp_pp, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    drive_cycle(14'd0);

    // Ramp 8000.. with level 8192: trigger on 8192, last entry 8703.
    run_capture(0, 8192, 1'b0, 0, 8000, bc);
    read_at(0, v);
    chk("ramp_first", v, 8192);
    read_at(511, v);
    chk("ramp_last", v, 8703);

    // Randomized captures: random decimation, level, and force.
    for (int t = 0; t < 3; t++)
      run_capture(int'($urandom_range(3, 0)), int'($urandom_range(12000, 4000)),
                  1'($urandom_range(1, 0)), 1, 0, bc);

    // Forced capture of a constant at div=3: 4-clock strobes, busy >= 2048.
    run_capture(3, 8192, 1'b1, 2, 5000, bc);
    chk("const_busy_len", bc >= 2048, 1);
    chk("const_amp_pp", amp_pp, 0);

    // Reset around write 100 aborts the capture.
    hist.delete();
    state_div = 8'd0; trig_force = 1'b1; arm = 1'b1;
    drive_cycle(14'd1234);
    arm = 1'b0;
    repeat (100) drive_cycle(14'($urandom_range(16383, 0)));
    chk("midcap_busy", busy, 1);
    rst = 1'b1;
    drive_cycle(14'd0);
    rst = 1'b0; trig_force = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pk_min", pk_min, PEAK ? 16383 : 0);
    chk("abort_pk_max", pk_max, 0);
    chk("abort_amp_pp", amp_pp, 0);
    chk("abort_rd_data", rd_data, 0);

    // A new arm after the abort captures normally.
    run_capture(0, 8192, 1'b0, 0, 8000, bc);

    // Stuck above level without force: stays armed; re-arm ignored; en drops.
    hist.delete();
    state_div = 8'd0; state_trig_level = 14'd8192; arm = 1'b1;
    drive_cycle(14'd9000);
    arm = 1'b0;
    repeat (3000) drive_cycle(14'd9000);
    chk("stuck_busy", busy, 1);
    chk("stuck_done", done, 0);
    arm = 1'b1;
    drive_cycle(14'd9000);
    arm = 1'b0;
    chk("rearm_busy", busy, 1);
    en = 1'b0;
    drive_cycle(14'd9000);
    chk("en_low_busy", busy, 0);
    chk("en_low_done", done, 0);
    en = 1'b1;
    drive_cycle(14'd9000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
